io_print_rr_arbiter: RTL and testbench

IO_PRINT_RR_ARBITER -- requirements
Module: io_print_rr_arbiter

---
 rtl/io_print_rr_arbiter_pkg.sv | 26 ++
 rtl/io_print_fifo.sv | 66 ++++++
 rtl/io_print_rr_arbiter.sv | 87 ++++++++
 tb/tb_io_print_rr_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/io_print_rr_arbiter_pkg.sv
// Shared definitions for the two-core print arbiter: round-robin encodings,
// default sizes and the grant decision.
package io_print_rr_arbiter_pkg;

    typedef enum logic {
        RR_LAST_CORE0 = 1'b0,
        RR_LAST_CORE1 = 1'b1
    } rr_last_e;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    // Returns 1'b1 when core 1 wins; under contention the core not served last wins.
    function automatic logic grant_core1(input logic req0, input logic req1, input rr_last_e last);
        logic g;
        if (req0 && req1) begin
            g = (last == RR_LAST_CORE0) ? 1'b1 : 1'b0;
        end else if (req1) begin
            g = 1'b1;
        end else begin
            g = 1'b0;
        end
        return g;
    endfunction

endpackage

// File: rtl/io_print_fifo.sv
// Synchronous FIFO holding {core_id, data} print entries; power-of-two depth
// so the pointers wrap naturally.
module io_print_fifo
    import io_print_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_DATA_WIDTH + 1,
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CNT_MAX);
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign rd_data   = mem_r[rd_ptr_r];

    // Storage array; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/io_print_rr_arbiter.sv
// Round-robin arbiter merging two cores' print requests into one buffered,
// registered hex-display stream.
module io_print_rr_arbiter
    import io_print_rr_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_core0,
    input  logic [DATA_WIDTH-1:0] data_core0,
    input  logic                  req_core1,
    input  logic [DATA_WIDTH-1:0] data_core1,
    input  logic                  print_ready,
    output logic                  ack_core0,
    output logic                  ack_core1,
    output logic                  print_hex_enable,
    output logic [DATA_WIDTH-1:0] print_output,
    output logic                  print_core_id,
    output logic                  fifo_full
);

    rr_last_e              rr_last_r;
    logic                  grant_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  full_s;
    logic                  empty_s;
    logic [DATA_WIDTH:0]   wr_entry_s;
    logic [DATA_WIDTH:0]   rd_entry_s;

    // Grant, push/pop decisions and acks; everything is suppressed during reset.
    always_comb begin
        grant_s    = grant_core1(req_core0, req_core1, rr_last_r);
        push_s     = reset && (req_core0 || req_core1) && !full_s;
        pop_s      = reset && !empty_s && print_ready;
        ack_core0  = push_s && !grant_s;
        ack_core1  = push_s && grant_s;
        wr_entry_s = grant_s ? {1'b1, data_core1} : {1'b0, data_core0};
    end

    assign fifo_full = full_s && reset;

    io_print_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data (wr_entry_s),
        .rd_data (rd_entry_s),
        .full    (full_s),
        .empty   (empty_s)
    );

    // Round-robin history follows whichever core was accepted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_last_r <= RR_LAST_CORE1;
        end else if (push_s) begin
            rr_last_r <= grant_s ? RR_LAST_CORE1 : RR_LAST_CORE0;
        end else begin
            rr_last_r <= rr_last_r;
        end
    end

    // Output strobe carries the popped entry for exactly one cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            print_hex_enable <= 1'b0;
            print_output     <= {DATA_WIDTH{1'b0}};
            print_core_id    <= 1'b0;
        end else if (pop_s) begin
            print_hex_enable <= 1'b1;
            print_output     <= rd_entry_s[DATA_WIDTH-1:0];
            print_core_id    <= rd_entry_s[DATA_WIDTH];
        end else begin
            print_hex_enable <= 1'b0;
            print_output     <= {DATA_WIDTH{1'b0}};
            print_core_id    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_io_print_rr_arbiter.sv
// Directed-vector bench for io_print_rr_arbiter with hand-computed expectations.
module tb_io_print_rr_arbiter;

    logic        clk;
    logic        reset;
    logic        req_core0;
    logic [31:0] data_core0;
    logic        req_core1;
    logic [31:0] data_core1;
    logic        print_ready;
    logic        ack_core0;
    logic        ack_core1;
    logic        print_hex_enable;
    logic [31:0] print_output;
    logic        print_core_id;
    logic        fifo_full;

    int n_vec = 0;
    int n_err = 0;

    io_print_rr_arbiter #(
        .DATA_WIDTH (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_core0        (req_core0),
        .data_core0       (data_core0),
        .req_core1        (req_core1),
        .data_core1       (data_core1),
        .print_ready      (print_ready),
        .ack_core0        (ack_core0),
        .ack_core1        (ack_core1),
        .print_hex_enable (print_hex_enable),
        .print_output     (print_output),
        .print_core_id    (print_core_id),
        .fifo_full        (fifo_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic en, input logic [31:0] val, input logic id);
        chk({tag, "_en"}, {63'd0, print_hex_enable}, {63'd0, en});
        chk({tag, "_out"}, {32'd0, print_output}, {32'd0, val});
        chk({tag, "_id"}, {63'd0, print_core_id}, {63'd0, id});
    endtask

    task automatic chk_ack(input string tag, input logic a0, input logic a1);
        chk({tag, "_ack0"}, {63'd0, ack_core0}, {63'd0, a0});
        chk({tag, "_ack1"}, {63'd0, ack_core1}, {63'd0, a1});
    endtask

    initial begin
        // Reset with both requests pending
        reset = 1'b0; req_core0 = 1'b1; req_core1 = 1'b1;
        data_core0 = 32'hAAAA0000; data_core1 = 32'hBBBB1111; print_ready = 1'b1;
        tick(); tick();
        chk_ack("rst", 1'b0, 1'b0);
        chk_out("rst", 1'b0, 32'h0, 1'b0);
        chk("rst_full", {63'd0, fifo_full}, 64'd0);
        reset = 1'b1; req_core0 = 1'b0; req_core1 = 1'b0;
        #1;

        // Contention: rr_last starts at core1, so core0 goes first
        tick(); req_core0 = 1'b1; req_core1 = 1'b1;
        data_core0 = 32'hA0A0A0A0; data_core1 = 32'hB1B1B1B1; #1;
        chk_ack("cont0", 1'b1, 1'b0);
        tick();
        chk_ack("cont1", 1'b0, 1'b1);
        chk_out("cont1", 1'b0, 32'h0, 1'b0);
        tick();
        chk_ack("cont2", 1'b1, 1'b0);
        chk_out("cont2", 1'b1, 32'hA0A0A0A0, 1'b0);
        tick();
        chk_ack("cont3", 1'b0, 1'b1);
        chk_out("cont3", 1'b1, 32'hB1B1B1B1, 1'b1);
        tick(); req_core0 = 1'b0; req_core1 = 1'b0; #1;
        chk_ack("cont4", 1'b0, 1'b0);
        chk_out("cont4", 1'b1, 32'hA0A0A0A0, 1'b0);
        tick();
        chk_out("cont5", 1'b1, 32'hB1B1B1B1, 1'b1);
        tick();
        chk_out("cont6", 1'b0, 32'h0, 1'b0);

        // Single request latency: ack in N, strobe in N+2
        tick(); req_core0 = 1'b1; data_core0 = 32'hDEADBEEF; #1;
        chk_ack("single0", 1'b1, 1'b0);
        tick(); req_core0 = 1'b0; #1;
        chk_out("single1", 1'b0, 32'h0, 1'b0);
        tick();
        chk_out("single2", 1'b1, 32'hDEADBEEF, 1'b0);
        tick();
        chk_out("single3", 1'b0, 32'h0, 1'b0);

        // Backpressure: only four entries fit while the sink is stalled
        tick(); print_ready = 1'b0; req_core1 = 1'b1; data_core1 = 32'h1; #1;
        chk_ack("bp1", 1'b0, 1'b1);
        chk("bp1_full", {63'd0, fifo_full}, 64'd0);
        tick(); data_core1 = 32'h2; #1;
        chk_ack("bp2", 1'b0, 1'b1);
        tick(); data_core1 = 32'h3; #1;
        chk_ack("bp3", 1'b0, 1'b1);
        tick(); data_core1 = 32'h4; #1;
        chk_ack("bp4", 1'b0, 1'b1);
        tick(); data_core1 = 32'h5; #1;
        chk_ack("bp5", 1'b0, 1'b0);
        chk("bp5_full", {63'd0, fifo_full}, 64'd1);
        chk_out("bp5", 1'b0, 32'h0, 1'b0);
        tick(); print_ready = 1'b1; #1;
        chk_ack("bp6", 1'b0, 1'b0);
        chk("bp6_full", {63'd0, fifo_full}, 64'd1);
        tick();
        chk_ack("bp7", 1'b0, 1'b1);
        chk("bp7_full", {63'd0, fifo_full}, 64'd0);
        chk_out("bp7", 1'b1, 32'h1, 1'b1);
        tick(); data_core1 = 32'h6; #1;
        chk_ack("bp8", 1'b0, 1'b1);
        chk_out("bp8", 1'b1, 32'h2, 1'b1);
        tick(); req_core1 = 1'b0; #1;
        chk_out("bp9", 1'b1, 32'h3, 1'b1);
        tick();
        chk_out("bp10", 1'b1, 32'h4, 1'b1);
        tick();
        chk_out("bp11", 1'b1, 32'h5, 1'b1);
        tick();
        chk_out("bp12", 1'b1, 32'h6, 1'b1);
        tick();
        chk_out("bp13", 1'b0, 32'h0, 1'b0);

        // Simultaneous push and pop at occupancy 2
        tick(); print_ready = 1'b0; req_core0 = 1'b1; data_core0 = 32'h11; #1;
        chk_ack("pp1", 1'b1, 1'b0);
        tick(); data_core0 = 32'h22; #1;
        chk_ack("pp2", 1'b1, 1'b0);
        tick(); req_core0 = 1'b0; print_ready = 1'b1; req_core1 = 1'b1; data_core1 = 32'h33; #1;
        chk_ack("pp3", 1'b0, 1'b1);
        tick(); req_core1 = 1'b0; print_ready = 1'b0; #1;
        chk_out("pp4", 1'b1, 32'h11, 1'b0);
        tick(); req_core0 = 1'b1; data_core0 = 32'h44; #1;
        chk_out("pp5", 1'b0, 32'h0, 1'b0);
        chk_ack("pp5", 1'b1, 1'b0);
        chk("pp5_full", {63'd0, fifo_full}, 64'd0);
        tick(); data_core0 = 32'h55; #1;
        chk_ack("pp6", 1'b1, 1'b0);
        tick(); data_core0 = 32'h66; #1;
        chk_ack("pp7", 1'b0, 1'b0);
        chk("pp7_full", {63'd0, fifo_full}, 64'd1);
        tick(); req_core0 = 1'b0; print_ready = 1'b1; #1;
        tick();
        chk_out("pp9", 1'b1, 32'h22, 1'b0);
        tick();
        chk_out("pp10", 1'b1, 32'h33, 1'b1);
        tick();
        chk_out("pp11", 1'b1, 32'h44, 1'b0);
        tick();
        chk_out("pp12", 1'b1, 32'h55, 1'b0);
        tick();
        chk_out("pp13", 1'b0, 32'h0, 1'b0);

        // Reset mid-stream discards buffered entries
        tick(); print_ready = 1'b0; req_core0 = 1'b1; data_core0 = 32'h71; #1;
        chk_ack("mr1", 1'b1, 1'b0);
        tick(); data_core0 = 32'h72; #1;
        chk_ack("mr2", 1'b1, 1'b0);
        tick(); data_core0 = 32'h73; #1;
        chk_ack("mr3", 1'b1, 1'b0);
        tick(); req_core0 = 1'b0; reset = 1'b0; print_ready = 1'b1;
        req_core1 = 1'b1; data_core1 = 32'hEE; #1;
        chk_ack("mr4", 1'b0, 1'b0);
        tick(); reset = 1'b1; req_core1 = 1'b0; #1;
        chk_out("mr5", 1'b0, 32'h0, 1'b0);
        chk("mr5_full", {63'd0, fifo_full}, 64'd0);
        tick();
        chk_out("mr6", 1'b0, 32'h0, 1'b0);
        tick();
        chk_out("mr7", 1'b0, 32'h0, 1'b0);

        // Fresh push after reset still flows
        tick(); req_core1 = 1'b1; data_core1 = 32'h99; #1;
        chk_ack("np0", 1'b0, 1'b1);
        tick(); req_core1 = 1'b0; #1;
        chk_out("np1", 1'b0, 32'h0, 1'b0);
        tick();
        chk_out("np2", 1'b1, 32'h99, 1'b1);
        tick();
        chk_out("np3", 1'b0, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
